// File: rtl/lane_serializer_param.sv
// Round-robin serializer: LANES parallel WIDTH-bit lanes onto one MSB-first bit stream.
// One bit clock; slot and lane counters replace divided clocks; idle comma fills gaps.
module lane_serializer_param #(
    parameter int                LANES      = 4,
    parameter int                WIDTH      = 8,
    parameter logic [WIDTH-1:0]  IDLE_WORD  = 8'hBC,
    parameter int                SYNC_WORDS = 4,
    localparam int               LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     en_i,
    input  logic [LANES*WIDTH-1:0]   in_data_i,
    input  logic [LANES-1:0]         in_valid_i,
    output logic                     data_out_o,
    output logic [LANES-1:0]         word_ack_o,
    output logic [LW-1:0]            lane_idx_o,
    output logic                     frame_start_o,
    output logic                     active_o
);

    localparam int BW  = $clog2(WIDTH);
    localparam int SCW = $clog2(SYNC_WORDS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [SCW-1:0]   sync_cnt_q, sync_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [LANES-1:0] ack_q, ack_d;
    logic             fs_q, fs_d;
    logic             active_q, active_d;

    logic             boundary_s;
    logic [WIDTH-1:0] lane_word_s;
    logic             lane_valid_s;
    logic [LANES-1:0] lane_onehot_s;

    // Select the word, valid bit and ack position of the lane owning the current slot
    always_comb begin
        lane_word_s   = '0;
        lane_valid_s  = 1'b0;
        lane_onehot_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_q == LW'(i)) begin
                lane_word_s      = in_data_i[i*WIDTH +: WIDTH];
                lane_valid_s     = in_valid_i[i];
                lane_onehot_s[i] = 1'b1;
            end else begin
                lane_onehot_s[i] = 1'b0;
            end
        end
    end

    // Free-running bit and lane counters; they never stop, whatever the state
    always_comb begin
        boundary_s = (bit_cnt_q == '0);
        lane_d     = lane_q;
        if (bit_cnt_q == BW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (lane_q == LW'(LANES - 1)) begin
                lane_d = '0;
            end else begin
                lane_d = lane_q + LW'(1);
            end
        end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
        end
    end

    // State transitions and word loading, both only on slot boundaries
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
        ack_d      = '0;
        fs_d       = 1'b0;
        active_d   = active_q;
        if (boundary_s) begin
            fs_d    = (lane_q == '0);
            shreg_d = IDLE_WORD;
            case (state_q)
                ST_IDLE: begin
                    if (en_i) begin
                        state_d    = ST_SYNC;
                        sync_cnt_d = SCW'(1);
                    end else begin
                        state_d    = ST_IDLE;
                        sync_cnt_d = '0;
                    end
                end
                ST_SYNC: begin
                    if (!en_i) begin
                        state_d    = ST_IDLE;
                        sync_cnt_d = '0;
                    end else if ((sync_cnt_q >= SCW'(SYNC_WORDS)) && (lane_q == '0)) begin
                        state_d    = ST_ACTIVE;
                        sync_cnt_d = '0;
                    end else if (sync_cnt_q < SCW'(SYNC_WORDS)) begin
                        sync_cnt_d = sync_cnt_q + SCW'(1);
                    end else begin
                        sync_cnt_d = sync_cnt_q;
                    end
                end
                ST_ACTIVE: begin
                    if (!en_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    sync_cnt_d = '0;
                end
            endcase
            // The boundary that enters ACTIVE already carries lane data
            if ((state_d == ST_ACTIVE) && lane_valid_s) begin
                shreg_d = lane_word_s;
                ack_d   = lane_onehot_s;
            end else begin
                ack_d = '0;
            end
            active_d = (state_d == ST_ACTIVE);
        end else begin
            fs_d = 1'b0;
        end
    end

    // State registers; reset aborts any slot in progress
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            lane_q     <= '0;
            sync_cnt_q <= '0;
            shreg_q    <= '0;
            ack_q      <= '0;
            fs_q       <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            lane_q     <= lane_d;
            sync_cnt_q <= sync_cnt_d;
            shreg_q    <= shreg_d;
            ack_q      <= ack_d;
            fs_q       <= fs_d;
            active_q   <= active_d;
        end
    end

    assign data_out_o    = shreg_q[WIDTH-1];
    assign word_ack_o    = ack_q;
    assign lane_idx_o    = lane_q;
    assign frame_start_o = fs_q;
    assign active_o      = active_q;

endmodule

// File: tb/tb_lane_serializer_param.sv
// Bench for lane_serializer_param: slot table on the default instance, hand sequences
// for mid-slot reset and a LANES=2/WIDTH=10 instance.
module tb_lane_serializer_param;

    typedef struct {
        logic        en;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        mid_en;
        logic [3:0]  mid_valid;
        logic [7:0]  exp_word;
        logic [3:0]  exp_ack;
        logic        exp_act;
    } vec_t;

    typedef struct {
        logic [15:0] word;
        logic [3:0]  ack;
        logic        act;
        logic [1:0]  lane;
        logic        fs;
    } exp_t;

    logic        clk;
    logic        rst_a_n, en_a, dout_a, fs_a, act_a;
    logic [31:0] data_a;
    logic [3:0]  valid_a, ack_a;
    logic [1:0]  lane_a;
    logic        rst_b_n, en_b, dout_b, fs_b, act_b;
    logic [19:0] data_b;
    logic [1:0]  valid_b, ack_b;
    logic [0:0]  lane_b;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   a_slot = 0;

    lane_serializer_param dut_a (
        .clk_i(clk), .reset_ni(rst_a_n), .en_i(en_a), .in_data_i(data_a), .in_valid_i(valid_a),
        .data_out_o(dout_a), .word_ack_o(ack_a), .lane_idx_o(lane_a),
        .frame_start_o(fs_a), .active_o(act_a)
    );

    lane_serializer_param #(
        .LANES(2), .WIDTH(10), .IDLE_WORD(10'h17C), .SYNC_WORDS(3)
    ) dut_b (
        .clk_i(clk), .reset_ni(rst_b_n), .en_i(en_b), .in_data_i(data_b), .in_valid_i(valid_b),
        .data_out_o(dout_b), .word_ack_o(ack_b), .lane_idx_o(lane_b),
        .frame_start_o(fs_b), .active_o(act_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic void addm(input logic en, input logic [3:0] valid, input logic [31:0] data,
                                 input logic mid_en, input logic [3:0] mid_valid,
                                 input logic [7:0] word, input logic [3:0] ack, input logic act);
        vec_t v;
        v.en = en; v.valid = valid; v.data = data; v.mid_en = mid_en; v.mid_valid = mid_valid;
        v.exp_word = word; v.exp_ack = ack; v.exp_act = act;
        vecs.push_back(v);
    endfunction

    function automatic void add(input logic en, input logic [3:0] valid, input logic [31:0] data,
                                input logic [7:0] word, input logic [3:0] ack, input logic act);
        addm(en, valid, data, en, valid, word, ack, act);
    endfunction

    // Drive one slot of instance A; the DUT output for it is checked against the scoreboard.
    task automatic run_vec(input vec_t v);
        exp_t       e;
        logic [7:0] got;
        got = 8'h00;
        en_a = v.en; valid_a = v.valid; data_a = v.data;
        e.word = {8'h00, v.exp_word}; e.ack = v.exp_ack; e.act = v.exp_act;
        e.lane = 2'(a_slot % 4); e.fs = ((a_slot % 4) == 0);
        sb.push_back(e);
        a_slot++;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            got = {got[6:0], dout_a};
            if (k == 0) begin
                e = sb.pop_front();
                check("a_ack", 32'(ack_a), 32'(e.ack));
                check("a_active", 32'(act_a), 32'(e.act));
                check("a_lane", 32'(lane_a), 32'(e.lane));
                check("a_frame_start", 32'(fs_a), 32'(e.fs));
            end
            if (k == 1) begin
                check("a_ack_pulse", 32'(ack_a), 32'd0);
                check("a_fs_pulse", 32'(fs_a), 32'd0);
            end
            if (k == 3) begin
                en_a = v.mid_en; valid_a = v.mid_valid;
            end
            if (k < 7) @(posedge clk);
        end
        check("a_word", 32'(got), 32'(e.word[7:0]));
    endtask

    logic [31:0] d0, d1;
    logic [9:0]  bw   [6];
    logic [1:0]  back [6];
    logic        bact [6];

    initial begin
        exp_t       e;
        logic [9:0] gb;

        d0 = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        d1 = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) add(1'b1, 4'hF, d0, 8'hBC, 4'h0, 1'b0);
        add(1'b1, 4'hF, d0, 8'hA1, 4'h1, 1'b1);
        add(1'b1, 4'hF, d0, 8'hB2, 4'h2, 1'b1);
        add(1'b1, 4'hF, d0, 8'hC3, 4'h4, 1'b1);
        add(1'b1, 4'hF, d0, 8'hD4, 4'h8, 1'b1);
        add(1'b1, 4'hA, d1, 8'hBC, 4'h0, 1'b1);
        add(1'b1, 4'hA, d1, 8'h22, 4'h2, 1'b1);
        add(1'b1, 4'hA, d1, 8'hBC, 4'h0, 1'b1);
        add(1'b1, 4'hA, d1, 8'h44, 4'h8, 1'b1);
        // en pulses low mid-slot but is high again at the boundary: no effect
        addm(1'b1, 4'hF, d1, 1'b0, 4'hF, 8'h11, 4'h1, 1'b1);
        add(1'b1, 4'hF, d1, 8'h22, 4'h2, 1'b1);
        // en drops mid lane-2 slot: that word completes, next boundary is idle
        addm(1'b1, 4'hF, d1, 1'b0, 4'hF, 8'h33, 4'h4, 1'b1);
        add(1'b0, 4'hF, d1, 8'hBC, 4'h0, 1'b0);
        add(1'b0, 4'hF, d1, 8'hBC, 4'h0, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b1, 4'hF, d1, 8'hBC, 4'h0, 1'b0);
        add(1'b1, 4'hF, d1, 8'h11, 4'h1, 1'b1);
        addm(1'b1, 4'hF, d1, 1'b1, 4'h0, 8'h22, 4'h2, 1'b1);
        add(1'b1, 4'h0, d1, 8'hBC, 4'h0, 1'b1);
        add(1'b1, 4'h8, d1, 8'h44, 4'h8, 1'b1);
        add(1'b0, 4'hF, d1, 8'hBC, 4'h0, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b1, 4'hF, d1, 8'hBC, 4'h0, 1'b0);
        // SYNC exit condition met on the same boundary en falls: back to IDLE
        add(1'b0, 4'hF, d1, 8'hBC, 4'h0, 1'b0);
        add(1'b1, 4'hF, d1, 8'hBC, 4'h0, 1'b0);

        bw   = '{10'h17C, 10'h17C, 10'h17C, 10'h17C, 10'h2AA, 10'h155};
        back = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
        bact = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_a_n = 1'b0; en_a = 1'b0; data_a = '0; valid_a = '0;
        rst_b_n = 1'b0; en_b = 1'b0; data_b = '0; valid_b = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(dout_a), 32'd0);
        check("rst_ack", 32'(ack_a), 32'd0);
        check("rst_active", 32'(act_a), 32'd0);
        check("rst_lane", 32'(lane_a), 32'd0);
        check("rst_fs", 32'(fs_a), 32'd0);
        rst_a_n = 1'b1;
        a_slot = 0;
        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted in cycle 3 of a data slot
        @(negedge clk);
        rst_a_n = 1'b0;
        @(negedge clk);
        rst_a_n = 1'b1;
        a_slot = 0;
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        en_a = 1'b1; valid_a = 4'hF; data_a = d0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_rst_dout", 32'(dout_a), 32'd1);
        check("pre_rst_lane", 32'(lane_a), 32'd1);
        check("pre_rst_active", 32'(act_a), 32'd1);
        rst_a_n = 1'b0;
        #1;
        check("async_rst_dout", 32'(dout_a), 32'd0);
        check("async_rst_ack", 32'(ack_a), 32'd0);
        check("async_rst_active", 32'(act_a), 32'd0);
        check("async_rst_lane", 32'(lane_a), 32'd0);
        @(negedge clk);
        rst_a_n = 1'b1;
        a_slot = 0;
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Two 10-bit lanes, three sync words
        en_a = 1'b0;
        check("b_rst_dout", 32'(dout_b), 32'd0);
        rst_b_n = 1'b1; en_b = 1'b1; valid_b = 2'b11; data_b = {10'h155, 10'h2AA};
        for (int s = 0; s < 6; s++) begin
            e.word = {6'd0, bw[s]}; e.ack = {2'b00, back[s]}; e.act = bact[s];
            e.lane = 2'(s % 2); e.fs = ((s % 2) == 0);
            sb.push_back(e);
            gb = '0;
            @(posedge clk);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                gb = {gb[8:0], dout_b};
                if (k == 0) begin
                    e = sb.pop_front();
                    check("b_ack", 32'(ack_b), 32'(e.ack));
                    check("b_active", 32'(act_b), 32'(e.act));
                    check("b_lane", 32'(lane_b), 32'(e.lane));
                    check("b_frame_start", 32'(fs_b), 32'(e.fs));
                end
                if (k == 1) begin
                    check("b_ack_pulse", 32'(ack_b), 32'd0);
                    check("b_fs_pulse", 32'(fs_b), 32'd0);
                end
                if (k < 9) @(posedge clk);
            end
            check("b_word", 32'(gb), 32'(e.word[9:0]));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lane_serializer_param.md
# lane_serializer_param

Parametrised successor to the fixed 4-lane, 8-bit, multi-clock transmit path. It round-robins `LANES` parallel lanes of `WIDTH`-bit words into one serial bit stream, MSB first, using a single bit-rate clock with internal slot and lane counters instead of divided clocks. Invalid lanes, the post-reset/re-enable training sequence, and the disabled state all emit the idle comma word. It sits at the PHY transmit edge, between the lane sources and the serial line.

## Interface
- `LANES`, default 4: number of input lanes; ≥1.
- `WIDTH`, default 8: bits per word, and bit-clock cycles per slot; ≥2.
- `IDLE_WORD`, default 8'hBC: comma/idle word; `WIDTH` bits.
- `SYNC_WORDS`, default 4: minimum idle words sent in SYNC; ≥1.
- `clk` input 1: bit clock, rising edge. One clock only.
- `reset` input 1: asynchronous, active-low reset.
- `en` input 1: transmit enable; sampled only at slot boundaries.
- `in_data` input `LANES*WIDTH`: lane i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid` input `LANES`: per-lane valid.
- `data_out` output 1: serial bit, registered.
- `word_ack` output `LANES`: one-hot pulse; lane i's word was consumed.
- `lane_idx` output `$clog2(LANES)` (min 1): lane of the current slot.
- `frame_start` output 1: pulse on the lane-0 slot start edge.
- `active` output 1: high while in ACTIVE.

## Operation
- Counters:
  - `bit_cnt` runs 0..WIDTH-1 and wraps.
  - `lane_idx` advances when `bit_cnt` wraps; it goes LANES-1 → 0.
  - A slot boundary is the edge taken with `bit_cnt==0`.
  - Both counters always run, in every state.
- States: IDLE, SYNC, ACTIVE. Transitions are evaluated only at slot boundaries.
  - IDLE: sends `IDLE_WORD`. Moves to SYNC when `en==1`.
  - SYNC: sends `IDLE_WORD`; `sync_cnt` counts words sent.
    - Moves to IDLE if `en==0`.
    - Moves to ACTIVE at the first boundary where `sync_cnt ≥ SYNC_WORDS` and `lane_idx==0`.
  - ACTIVE: at each boundary, the word for `lane_idx` is loaded. It is `in_data` slice if `in_valid[lane_idx]`, else `IDLE_WORD`.
    - Moves to IDLE if `en==0` at a boundary; the slot in progress always completes.
- State-change timing:
  - The boundary edge that changes state already loads the new state's word.
  - `en` falling makes that same boundary load `IDLE_WORD`.
- `word_ack[lane_idx]`: pulses for one cycle on an ACTIVE boundary only when the valid word is loaded. No ack is given for idle substitution.
- Shift register: loaded with the word at the boundary and shifted left each following edge.
  - `data_out` equals word bit `WIDTH-1-k` during cycle k of the slot.
- Reset:
  - All state goes to IDLE, counters to 0, `sync_cnt` to 0, shift register to 0.
  - Outputs go to 0: `data_out`, `word_ack`, `frame_start`, `active`, `lane_idx`.
  - Reset asserted mid-slot aborts that slot immediately, with no completion.

## Timing
- First edge after reset release is a boundary, with `bit_cnt==0` and `lane_idx==0`.
- Latency: a word sampled at boundary edge E drives its MSB on `data_out` from E to E+1; its LSB appears from E+WIDTH-1 to E+WIDTH.
- Frame period: `LANES*WIDTH` cycles. `frame_start` and `word_ack` are asserted exactly on boundary edges.
- Minimum en-to-data: `en` high at boundary B gives at least `SYNC_WORDS` idle slots after the IDLE→SYNC boundary. The first data is at the next lane-0 boundary.
- Simultaneous events:
  - `en` low together with the SYNC exit condition: IDLE wins.
  - `in_valid` changing mid-slot has no effect; the value is sampled only at that lane's boundary.
- `LANES==1`: `lane_idx` stays 0 and every boundary is a frame start.

## Test plan
- Reset, `en=1`, defaults, all valid:
  - Required: 4 idle slots (bits 1,0,1,1,1,1,0,0 each), then lane0..lane3 data MSB first.
  - Required: `active` rises at cycle 32; `word_ack` is 0001, 0010, 0100, 1000 at cycles 32, 40, 48, 56.
- `in_valid=4'b1010`, data 8'h11,8'h22,8'h33,8'h44:
  - Required: stream BC,22,BC,44 per frame.
  - Required: `word_ack` pulses only for lanes 1 and 3.
- `en` dropped mid-slot of lane 2 in ACTIVE:
  - Required: lane 2 word finishes; the next boundary sends BC and `active=0`.
  - Required: after re-enable, ≥4 BC slots, then data resumes at lane 0.
- Reset asserted at cycle 3 of a data slot:
  - Required: `data_out`, `word_ack`, `active`, `lane_idx` are 0 immediately, without waiting for a clock.
  - Required: the sequence restarts from the IDLE/SYNC flow.
- Params `LANES=2, WIDTH=10, IDLE_WORD=10'h17C, SYNC_WORDS=3`:
  - Required: SYNC lasts 4 slots, exiting on the lane-0 alignment; frame is 20 cycles.
  - Required: 10'h2AA serialises as 1010101010.
